writeback_arbiter: RTL and testbench

- Drives the single register-file write port (write_enable/write_reg/write_data) from two producers: the single-cycle ALU path and the variable-latency load path.
- Loads are buffered in a small FIFO and drained when the ALU path is idle.
- A starvation guard periodically back-pressures the ALU so loads always drain.
- Exports a pending-destination mask to the hazard unit.

---
 rtl/writeback_arbiter.sv | 114 +++++++++++
 tb/tb_writeback_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results take priority, and
// buffered load results drain on idle cycles or when the starvation guard fires.
module writeback_arbiter #(
  parameter int LOAD_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_reg,
  input  logic [31:0]                   alu_data,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4:0]                    load_reg,
  input  logic [31:0]                   load_data,
  output logic                          write_enable,
  output logic [4:0]                    write_reg,
  output logic [31:0]                   write_data,
  output logic [31:0]                   pending,
  output logic [$clog2(LOAD_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(LOAD_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Handshake: a transfer happens on a posedge where valid && ready are both 1.
  // ready never depends on valid; a producer holds its payload until it transfers.

  logic [4:0]    reg_mem  [LOAD_DEPTH];
  logic [31:0]   data_mem [LOAD_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic alu_grant;

  assign full       = (count == CW'(LOAD_DEPTH));
  assign empty      = (count == '0);
  assign load_ready = !full;
  assign alu_ready  = (starve_cnt != SW'(STARVE_LIMIT));
  assign alu_grant  = alu_valid && alu_ready;
  assign enq        = load_valid && load_ready;
  assign deq        = !alu_grant && !empty;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        reg_mem[wr_ptr]  <= load_reg;
        data_mem[wr_ptr] <= load_data;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Counts ALU wins over a waiting load; any dequeue or an empty FIFO clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (deq || empty) begin
      starve_cnt <= '0;
    end else if (alu_grant) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
    end else if (alu_grant) begin
      write_enable <= (alu_reg != 5'd0);
      write_reg    <= alu_reg;
      write_data   <= alu_data;
    end else if (deq) begin
      write_enable <= (reg_mem[rd_ptr] != 5'd0);
      write_reg    <= reg_mem[rd_ptr];
      write_data   <= data_mem[rd_ptr];
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] offset;
    pending = '0;
    offset  = '0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if (CW'(offset) < count) begin
        pending[reg_mem[i]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (LOAD_DEPTH=4, STARVE_LIMIT=4).
module tb_writeback_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_reg;
  logic [31:0] load_data;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int checks;
  int failures;

  writeback_arbiter #(.LOAD_DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_reg(load_reg), .load_data(load_data),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .pending(pending), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    alu_valid  = 1'b0;
    load_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    load_valid = 1'b0; load_reg = '0; load_data = '0;
    step(); step();
    reset = 1'b1;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", write_enable); end
    checks++; if (write_reg !== 5'd0) begin failures++; $display("FAIL reset_reg: got %0d expected 0", write_reg); end
    checks++; if (write_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", write_data); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL reset_pending: got %h expected 0", pending); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
  endtask

  task automatic test_alu_single();
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL alu_we: got %b expected 1", write_enable); end
    checks++; if (write_reg !== 5'd5) begin failures++; $display("FAIL alu_reg: got %0d expected 5", write_reg); end
    checks++; if (write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data: got %h expected deadbeef", write_data); end
    step();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL alu_we_drop: got %b expected 0", write_enable); end
    checks++; if (write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL alu_hold: got %0d/%h expected 5/deadbeef", write_reg, write_data);
    end
  endtask

  task automatic test_back_to_back();
    alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'h11111111;
    step();
    alu_reg = 5'd2; alu_data = 32'h22222222;
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd1 || write_data !== 32'h11111111) begin
      failures++; $display("FAIL b2b_first: got %b/%0d/%h expected 1/1/11111111", write_enable, write_reg, write_data);
    end
    step();
    alu_valid = 1'b0;
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd2 || write_data !== 32'h22222222) begin
      failures++; $display("FAIL b2b_second: got %b/%0d/%h expected 1/2/22222222", write_enable, write_reg, write_data);
    end
    step();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b expected 0", write_enable); end
  endtask

  task automatic test_load_drain();
    load_valid = 1'b1; load_reg = 5'd7; load_data = 32'h12345678;
    step();
    load_valid = 1'b0;
    checks++; if (pending !== 32'h0000_0080) begin failures++; $display("FAIL load_pending_set: got %h expected 00000080", pending); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL load_count: got %0d expected 1", fifo_count); end
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL load_early_we: got %b expected 0", write_enable); end
    step();
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h12345678) begin
      failures++; $display("FAIL load_write: got %b/%0d/%h expected 1/7/12345678", write_enable, write_reg, write_data);
    end
    checks++; if (pending !== 32'd0) begin failures++; $display("FAIL load_pending_clr: got %h expected 0", pending); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL load_count_empty: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_full_wrap();
    int  k;
    int  got;
    bit  saw_full;
    bit  accepted;
    int  max_count;
    k = 1; got = 0; saw_full = 0; max_count = 0;
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h000000A1;
    load_valid = 1'b1; load_reg = 5'd1; load_data = 32'h101;
    for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (fifo_count == 3'd4 && !saw_full) begin
        saw_full = 1;
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_load_ready: got %b expected 0", load_ready); end
      end
      accepted = load_valid && load_ready;
      step();
      if (accepted) begin
        k++;
        if (k > 6) begin
          load_valid = 1'b0;
          alu_valid  = 1'b0;
        end else begin
          load_reg  = 5'(k);
          load_data = 32'h100 + 32'(k);
        end
      end
      if (write_enable === 1'b1 && write_reg !== 5'd20) begin
        checks++;
        if (write_reg !== 5'(got + 1) || write_data !== 32'h100 + 32'(got + 1)) begin
          failures++; $display("FAIL wrap_order: got %0d/%h expected %0d/%h", write_reg, write_data, got + 1, 32'h100 + 32'(got + 1));
        end
        got++;
      end
    end
    checks++; if (!saw_full) begin failures++; $display("FAIL full_reached: got max count %0d expected 4", max_count); end
    checks++; if (max_count > 4) begin failures++; $display("FAIL full_overflow: got max count %0d expected 4", max_count); end
    checks++; if (got != 6) begin failures++; $display("FAIL wrap_drain: got %0d load writes expected 6", got); end
    alu_valid = 1'b0; load_valid = 1'b0;
  endtask

  task automatic test_starvation();
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
    load_valid = 1'b1; load_reg = 5'd9; load_data = 32'h99;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL starve_ready_%0d: got %b expected 1", i, alu_ready); end
      step();
      checks++; if (write_enable !== 1'b1 || write_reg !== 5'd3) begin
        failures++; $display("FAIL starve_alu_%0d: got %b/%0d expected 1/3", i, write_enable, write_reg);
      end
    end
    checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL starve_block: got %b expected 0", alu_ready); end
    step();
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h99) begin
      failures++; $display("FAIL starve_load: got %b/%0d/%h expected 1/9/99", write_enable, write_reg, write_data);
    end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL starve_release: got %b expected 1", alu_ready); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL starve_count: got %0d expected 0", fifo_count); end
    step();
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd3) begin
      failures++; $display("FAIL starve_after: got %b/%0d expected 1/3", write_enable, write_reg);
    end
    alu_valid = 1'b0;
  endtask

  task automatic test_r0();
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hAAAA0000;
    step();
    alu_valid = 1'b0;
    checks++; if (write_enable !== 1'b0 || write_reg !== 5'd0) begin
      failures++; $display("FAIL r0_alu: got %b/%0d expected 0/0", write_enable, write_reg);
    end
    load_valid = 1'b1; load_reg = 5'd0; load_data = 32'hBBBB0000;
    step();
    load_valid = 1'b0;
    checks++; if (pending !== 32'd0 || fifo_count !== 3'd1) begin
      failures++; $display("FAIL r0_pending: got %h/%0d expected 0/1", pending, fifo_count);
    end
    step();
    checks++; if (write_enable !== 1'b0 || fifo_count !== 3'd0 || write_data !== 32'hBBBB0000) begin
      failures++; $display("FAIL r0_load: got %b/%0d/%h expected 0/0/bbbb0000", write_enable, fifo_count, write_data);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    alu_valid = 1'b1; alu_reg = 5'd30; alu_data = 32'h30;
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_reg = 5'(11 + i); load_data = 32'(i);
      step();
    end
    load_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3 || pending !== 32'h0000_3800) begin
      failures++; $display("FAIL mid_buffered: got %0d/%h expected 3/00003800", fifo_count, pending);
    end
    alu_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (fifo_count !== 3'd0 || pending !== 32'd0 || write_enable !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got %0d/%h/%b expected 0/0/0", fifo_count, pending, write_enable);
    end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (write_enable !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL mid_stray: got %0d writes expected 0", stray); end
    checks++; if (alu_ready !== 1'b1 || load_ready !== 1'b1) begin
      failures++; $display("FAIL mid_ready: got %b/%b expected 1/1", alu_ready, load_ready);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_alu_single();
    idle(2);
    test_back_to_back();
    idle(2);
    test_load_drain();
    idle(2);
    test_full_wrap();
    idle(3);
    test_starvation();
    idle(2);
    test_r0();
    idle(2);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
